// File: rtl/prbs8_checker.sv
// Receive-side checker for the x^8+x^6+x^5+x^4+1 Fibonacci LFSR word stream.
// Self-synchronises from received words, then free-runs a local LFSR to count word/bit errors.
module prbs8_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [7:0]  rx_data,
    input  logic        clr_counts,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] word_err_count,
    output logic [15:0] bit_err_count
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] x);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, x[i]};
        end
        return n;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  prev_q, prev_d;
    logic        prev_valid_q, prev_valid_d;
    logic [3:0]  match_cnt_q, match_cnt_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic [7:0]  expected_q, expected_d;
    logic        err_pulse_q, err_pulse_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;

    logic        search_hit;
    logic [3:0]  match_inc;
    logic [3:0]  miss_inc;
    logic [16:0] bit_sum;
    logic [15:0] word_sat_inc;
    logic [15:0] bit_sat_inc;

    // An all-zero word is the LFSR lock-up state and must never count as a match.
    assign search_hit   = prev_valid_q && (rx_data == lfsr_next(prev_q)) && (rx_data != 8'd0);
    assign match_inc    = match_cnt_q + 4'd1;
    assign miss_inc     = miss_cnt_q + 4'd1;
    assign bit_sum      = {1'b0, bit_cnt_q} + {13'd0, popcount8(rx_data ^ expected_q)};
    assign word_sat_inc = (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;
    assign bit_sat_inc  = bit_sum[16] ? 16'hFFFF : bit_sum[15:0];

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        expected_d   = expected_q;
        err_pulse_d  = 1'b0;
        word_cnt_d   = word_cnt_q;
        bit_cnt_d    = bit_cnt_q;

        if (ena) begin
            case (state_q)
                SEARCH: begin
                    prev_d       = rx_data;
                    prev_valid_d = 1'b1;
                    if (search_hit) begin
                        match_cnt_d = match_inc;
                        if (match_inc == LOCK_CNT) begin
                            state_d    = LOCKED;
                            expected_d = lfsr_next(rx_data);
                            miss_cnt_d = 4'd0;
                        end
                    end else begin
                        match_cnt_d = 4'd0;
                    end
                end
                LOCKED: begin
                    expected_d = lfsr_next(expected_q);
                    if (rx_data == expected_q) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        word_cnt_d  = word_sat_inc;
                        bit_cnt_d   = bit_sat_inc;
                        miss_cnt_d  = miss_inc;
                        // Re-seed the search from the losing word so resync starts immediately.
                        if (miss_inc == LOSS_CNT) begin
                            state_d      = SEARCH;
                            match_cnt_d  = 4'd0;
                            prev_d       = rx_data;
                            prev_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (clr_counts) begin
            word_cnt_d = 16'd0;
            bit_cnt_d  = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEARCH;
            prev_q       <= 8'd0;
            prev_valid_q <= 1'b0;
            match_cnt_q  <= 4'd0;
            miss_cnt_q   <= 4'd0;
            expected_q   <= 8'd0;
            err_pulse_q  <= 1'b0;
            word_cnt_q   <= 16'd0;
            bit_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            expected_q   <= expected_d;
            err_pulse_q  <= err_pulse_d;
            word_cnt_q   <= word_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    assign locked         = (state_q == LOCKED);
    assign err_pulse      = err_pulse_q;
    assign word_err_count = word_cnt_q;
    assign bit_err_count  = bit_cnt_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: lock, errors, loss/relock, zero stream, ena gaps,
// clear priority, reset mid-lock, and bit-counter saturation on a LOSS_COUNT=15 instance.
module tb_prbs8_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        ena_s = 1'b0;
    logic        clr_counts = 1'b0;
    logic [7:0]  rx_data = 8'd0;

    logic        locked, err_pulse;
    logic [15:0] word_err_count, bit_err_count;
    logic        locked_s, err_pulse_s;
    logic [15:0] word_err_count_s, bit_err_count_s;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    prbs8_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .rx_data        (rx_data),
        .clr_counts     (clr_counts),
        .locked         (locked),
        .err_pulse      (err_pulse),
        .word_err_count (word_err_count),
        .bit_err_count  (bit_err_count)
    );

    prbs8_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15)) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena_s),
        .rx_data        (rx_data),
        .clr_counts     (clr_counts),
        .locked         (locked_s),
        .err_pulse      (err_pulse_s),
        .word_err_count (word_err_count_s),
        .bit_err_count  (bit_err_count_s)
    );

    function automatic logic [7:0] nxt(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic l, input logic e,
                             input logic [15:0] w, input logic [15:0] b);
        check({tag, ".locked"}, {31'd0, locked}, {31'd0, l});
        check({tag, ".err_pulse"}, {31'd0, err_pulse}, {31'd0, e});
        check({tag, ".word"}, {16'd0, word_err_count}, {16'd0, w});
        check({tag, ".bit"}, {16'd0, bit_err_count}, {16'd0, b});
    endtask

    task automatic step(input logic e, input logic [7:0] d, input logic c);
        ena        = e;
        ena_s      = 1'b0;
        rx_data    = d;
        clr_counts = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step_s(input logic [7:0] d);
        ena        = 1'b0;
        ena_s      = 1'b1;
        rx_data    = d;
        clr_counts = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ena        = 1'b0;
        ena_s      = 1'b0;
        clr_counts = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Sends 0x01,0x02,0x04,0x08 (no lock yet) then 0x11 (lock).
    task automatic lock_seq(input string tag);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        step(1'b1, 8'h08, 1'b0);
        check({tag, ".pre_lock"}, {31'd0, locked}, 32'd0);
        step(1'b1, 8'h11, 1'b0);
        check({tag, ".lock"}, {31'd0, locked}, 32'd1);
    endtask

    initial begin
        logic [7:0] g;
        int         werr;
        int         berr;
        int         i;

        // Reset state
        do_reset();
        check_out("reset", 1'b0, 1'b0, 16'd0, 16'd0);

        // Lock, then two clean words
        lock_seq("lock");
        step(1'b1, 8'h23, 1'b0);
        check_out("clean1", 1'b1, 1'b0, 16'd0, 16'd0);
        step(1'b1, 8'h47, 1'b0);
        check_out("clean2", 1'b1, 1'b0, 16'd0, 16'd0);

        // Single one-bit error; free-running expected keeps the next word matching
        do_reset();
        lock_seq("lock_b");
        step(1'b1, 8'h22, 1'b0);
        check_out("single_err", 1'b1, 1'b1, 16'd1, 16'd1);
        step(1'b1, 8'h47, 1'b0);
        check_out("after_err", 1'b1, 1'b0, 16'd1, 16'd1);

        // Loss: expected 0x8E,0x1C,0x38 (popcounts 4,3,3) against zero words
        step(1'b1, 8'h00, 1'b0);
        check_out("loss1", 1'b1, 1'b1, 16'd2, 16'd5);
        step(1'b1, 8'h00, 1'b0);
        check_out("loss2", 1'b1, 1'b1, 16'd3, 16'd8);
        step(1'b1, 8'h00, 1'b0);
        check_out("loss3", 1'b0, 1'b1, 16'd4, 16'd11);

        // Relock needs LOCK_COUNT+1 valid words; the first one follows the seeded 0x00
        lock_seq("relock");
        check_out("relock_cnt", 1'b1, 1'b0, 16'd4, 16'd11);

        // Zero stream never locks
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'h00, 1'b0);
        end
        check_out("zero_stream", 1'b0, 1'b0, 16'd0, 16'd0);

        // Lock through ena gaps; gap data is ignored
        do_reset();
        step(1'b1, 8'h01, 1'b0);
        step(1'b0, 8'h55, 1'b0);
        check_out("gap1", 1'b0, 1'b0, 16'd0, 16'd0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b0, 8'hAA, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        step(1'b1, 8'h08, 1'b0);
        step(1'b0, 8'h11, 1'b0);
        check_out("gap2", 1'b0, 1'b0, 16'd0, 16'd0);
        step(1'b1, 8'h11, 1'b0);
        check_out("gap_lock", 1'b1, 1'b0, 16'd0, 16'd0);
        step(1'b0, 8'h99, 1'b0);
        check_out("gap_hold", 1'b1, 1'b0, 16'd0, 16'd0);
        step(1'b1, 8'h23, 1'b0);
        check_out("gap_match", 1'b1, 1'b0, 16'd0, 16'd0);

        // Clear beats a simultaneous increment
        step(1'b1, 8'h46, 1'b0);
        check_out("pre_clr_err", 1'b1, 1'b1, 16'd1, 16'd1);
        step(1'b1, 8'h8F, 1'b1);
        check_out("clr_with_err", 1'b1, 1'b1, 16'd0, 16'd0);
        step(1'b1, 8'h1C, 1'b0);
        check_out("post_clr", 1'b1, 1'b0, 16'd0, 16'd0);

        // Reset mid-lock, then a full search is needed
        g = 8'h38;
        rst = 1'b1; ena = 1'b1; rx_data = g;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_out("rst_mid", 1'b0, 1'b0, 16'd0, 16'd0);
        for (int k = 0; k < 4; k++) begin
            g = nxt(g);
            step(1'b1, g, 1'b0);
        end
        check("rst_relock_pre", {31'd0, locked}, 32'd0);
        g = nxt(g);
        step(1'b1, g, 1'b0);
        check("rst_relock", {31'd0, locked}, 32'd1);

        // Saturation of the bit counter on the LOSS_COUNT=15 instance
        do_reset();
        step_s(8'h01);
        step_s(8'h02);
        step_s(8'h04);
        step_s(8'h08);
        step_s(8'h11);
        check("sat.lock", {31'd0, locked_s}, 32'd1);
        g = 8'h23; werr = 0; berr = 0; i = 0;
        while (werr < 8191) begin
            if (i % 15 == 14) begin
                step_s(g);
            end else begin
                step_s(g ^ 8'hFF);
                werr++;
                berr += 8;
            end
            g = nxt(g);
            i++;
        end
        check("sat.bit_below", {16'd0, bit_err_count_s}, 32'(berr));
        check("sat.word_below", {16'd0, word_err_count_s}, 32'(werr));
        step_s(g ^ 8'hFF);
        g = nxt(g);
        check("sat.bit_clamp", {16'd0, bit_err_count_s}, 32'h0000FFFF);
        check("sat.word_8192", {16'd0, word_err_count_s}, 32'd8192);
        step_s(g ^ 8'hFF);
        check("sat.bit_hold", {16'd0, bit_err_count_s}, 32'h0000FFFF);
        check("sat.word_8193", {16'd0, word_err_count_s}, 32'd8193);
        check("sat.locked", {31'd0, locked_s}, 32'd1);
        check("sat.err_pulse", {31'd0, err_pulse_s}, 32'd1);
        ena_s = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/prbs8_checker.md
# prbs8_checker

Receive-side checker for the 8-bit Fibonacci LFSR pattern generator (x^8+x^6+x^5+x^4+1, one shift per enabled cycle, full state presented as a parallel word). It self-synchronises to the incoming word stream, declares lock after a run of consistent words, and then free-runs a local LFSR to count word and bit errors. It sits at the far end of the generator's output pins, on the loopback or companion tile, and drives lock and error status.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive correct transitions required to lock (1..15)
- LOSS_COUNT, 3: consecutive mismatching words while locked that drop lock (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  sample strobe; rx_data is valid only on cycles with ena=1
- rx_data  in  8  received LFSR word
- clr_counts  in  1  synchronous clear of both error counters
- locked  out  1  checker is in LOCKED state
- err_pulse  out  1  one-cycle flag: the word sampled last cycle mismatched while locked
- word_err_count  out  16  saturating count of mismatching words
- bit_err_count  out  16  saturating count of mismatching bits

## Operation
- next(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}. All-zero words are illegal and never count as a match.
- States: SEARCH (reset state), LOCKED.
- Registers: prev[7:0], prev_valid, match_cnt[3:0], miss_cnt[3:0], expected[7:0].
- ena=0: all state holds; err_pulse=0.
- SEARCH, ena=1:
  - prev<=rx_data, prev_valid<=1.
  - If prev_valid and rx_data==next(prev) and rx_data!=0, match_cnt++; otherwise match_cnt<=0.
  - If that increment reaches LOCK_COUNT: go LOCKED, expected<=next(rx_data), miss_cnt<=0.
  - No error counting in SEARCH.
- LOCKED, ena=1:
  - expected<=next(expected) unconditionally, so the local LFSR free-runs.
  - Match (rx_data==expected): miss_cnt<=0.
  - Mismatch: err_pulse<=1, word_err_count+=1, bit_err_count+=popcount(rx_data^expected), miss_cnt++.
  - Both counters saturate at 0xFFFF; the bit counter clamps and does not wrap.
  - If miss_cnt reaches LOSS_COUNT: go SEARCH, match_cnt<=0, prev<=rx_data, prev_valid<=1. The losing word is still counted as an error.
- clr_counts=1: both counters go to 0 on that edge. Clear beats a simultaneous increment, and that error is lost. err_pulse is unaffected.
- rst=1 (at any time, including mid-lock): state=SEARCH, prev=0, prev_valid=0, match_cnt=0, miss_cnt=0, expected=0, and all outputs 0. rst takes priority over ena and clr_counts.

## Timing
- All outputs are registered. Reset values: locked=0, err_pulse=0, word_err_count=0, bit_err_count=0.
- Lock latency: if words W0..WN arrive on consecutive ena cycles with N=LOCK_COUNT, locked rises the cycle after WN is sampled.
- err_pulse and the counters update the cycle after the offending word is sampled.
- Loss latency: locked falls the cycle after the LOSS_COUNT-th consecutive mismatching word is sampled.
- Gaps in ena only stretch these timings; the sequence check is per sample, not per clock.
- Throughput: one word per clock, no back-pressure.

## Test plan
- Lock: rst, then ena=1 with rx_data 0x01,0x02,0x04,0x08,0x11 on cycles 0-4 -> locked=1 from cycle 5. Then 0x23,0x47 -> err_pulse stays 0 and counters stay 0.
- Single error: locked as above, send 0x22 instead of 0x23, then 0x47 -> err_pulse=1 for one cycle, word_err_count=1, bit_err_count=1, locked stays 1. The following 0x47 matches, because expected free-runs.
- Loss and relock: locked, then 3 words of 0x00 -> word_err_count=3, locked=0 the cycle after the third word. Resume a valid sequence -> relock after LOCK_COUNT+1 valid words.
- Zero stream: rst, then 0x00 on every ena -> locked never asserts and counters stay 0.
- ena gaps and clear:
  - Lock sequence with ena=0 cycles interleaved -> lock still achieved, with held values during the gaps.
  - clr_counts on the same cycle as a mismatch -> counters read 0 and err_pulse=1.
- Saturation and reset:
  - Force sustained 0xFF^expected words with LOSS_COUNT=15 and periodic relock -> bit_err_count clamps at 0xFFFF.
  - Assert rst mid-lock -> all outputs 0 the next cycle, and relock requires a full search.
